// File: rtl/vga_write_queue.sv
// In-order write buffer between the execute/write-back stage and the VGA framebuffer port.
// Optional feature macro: VGA_WQ_COALESCE_EN (merge a write into the newest entry on address match).
module vga_write_queue #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 25,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_full,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: the head entry transfers on a rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready and the head holds until taken. The write side
    // has no ready: in_full is a registered stall, and a write that arrives while full is dropped.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic              pop;
    logic              push;
    logic              drop;
    logic              coalesce;

    assign out_valid = (count != '0);
    assign in_full   = (count == CNT_W'(DEPTH));
    assign out_addr  = addr_mem[rp];
    assign out_data  = data_mem[rp];
    assign pop       = out_valid && out_ready;

`ifdef VGA_WQ_COALESCE_EN
    logic [PTR_W-1:0] wp_last;
    assign wp_last  = wp - 1'b1;
    // A lone entry leaving this cycle cannot absorb the write; it becomes a normal push.
    assign coalesce = in_we && out_valid && (addr_mem[wp_last] == in_addr)
                      && !((count == CNT_W'(1)) && pop);
`else
    assign coalesce = 1'b0;
`endif

    assign push = in_we && !coalesce && !in_full;
    assign drop = in_we && !coalesce && in_full;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_mem[wp] <= in_addr;
            data_mem[wp] <= in_data;
        end
`ifdef VGA_WQ_COALESCE_EN
        if (!rst && coalesce) begin
            data_mem[wp_last] <= in_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_write_queue.sv
// Self-checking bench for vga_write_queue: directed vector table plus scoreboard-driven sequences.
module tb_vga_write_queue;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 25;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk_tb;
    logic              rst;
    logic              in_we;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_full;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    int n_checks = 0;
    int n_err    = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic                     exp_ovf;

    vga_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk_tb), .rst(rst), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
        .in_full(in_full), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .out_ready(out_ready), .count(count), .overflow(overflow)
    );

    // clock / reset block
    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    typedef struct {
        logic              rst;
        logic              we;
        logic              ready;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                exp_count;
        logic              exp_valid;
        logic              exp_full;
        logic              exp_ovf;
        logic              chk_head;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic rdy, int a, int d, int c, logic v,
                                logic f, logic o, logic h, int ea, int ed);
        vec_t t;
        t.rst = r; t.we = w; t.ready = rdy;
        t.addr = ADDR_W'(a); t.data = DATA_W'(d);
        t.exp_count = c; t.exp_valid = v; t.exp_full = f; t.exp_ovf = o;
        t.chk_head = h; t.exp_addr = ADDR_W'(ea); t.exp_data = DATA_W'(ed);
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".count"}, int'(count), exp_q.size());
        chk({tag, ".valid"}, int'(out_valid), int'(exp_q.size() != 0));
        chk({tag, ".full"}, int'(in_full), int'(exp_q.size() == DEPTH));
        chk({tag, ".ovf"}, int'(overflow), int'(exp_ovf));
    endtask

    // driver task with scoreboard model of the queue
    task automatic drive(input string tag, input logic we, input int a, input int d, input logic rdy);
        int   sz0;
        logic do_pop;
        logic merge;
        rst = 1'b0; in_we = we; in_addr = ADDR_W'(a); in_data = DATA_W'(d); out_ready = rdy;
        sz0 = exp_q.size();
        do_pop = rdy && (sz0 > 0);
        merge = 1'b0;
        if (do_pop) begin
            chk({tag, ".head_addr"}, int'(out_addr), int'(exp_q[0][ADDR_W+DATA_W-1:DATA_W]));
            chk({tag, ".head_data"}, int'(out_data), int'(exp_q[0][DATA_W-1:0]));
        end
`ifdef VGA_WQ_COALESCE_EN
        if (we && sz0 > 0 && exp_q[$][ADDR_W+DATA_W-1:DATA_W] == ADDR_W'(a)
            && !(sz0 == 1 && do_pop))
            merge = 1'b1;
`endif
        if (merge) exp_q[exp_q.size()-1] = {ADDR_W'(a), DATA_W'(d)};
        if (do_pop) void'(exp_q.pop_front());
        if (we && !merge) begin
            if (sz0 < DEPTH) exp_q.push_back({ADDR_W'(a), DATA_W'(d)});
            else exp_ovf = 1'b1;
        end
        step();
        in_we = 1'b0; out_ready = 1'b0;
        chk_status(tag);
    endtask

    task automatic do_reset(input string tag, input logic we_too);
        rst = 1'b1; in_we = we_too; in_addr = '0; in_data = '1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_we = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".valid"}, int'(out_valid), 0);
        chk({tag, ".full"}, int'(in_full), 0);
        chk({tag, ".ovf"}, int'(overflow), 0);
    endtask

    initial begin
        int writes;
        int guard;
        logic w;
        logic r;
        rst = 1'b1; in_we = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b0;
        exp_ovf = 1'b0;

        // reset, single write, fill past full, then drain in order
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 100, 42, 1, 1, 0, 0, 1, 100, 42));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 0, i, i * 3 + 5, i + 1, 1, i == 7, 0, 1, 0, 5));
        vecs.push_back(mk(0, 1, 0, 8, 29, 8, 1, 1, 1, 1, 0, 5));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 1, 0, 0, 8 - k, k < 8, 0, 1, k < 8, k, k * 3 + 5));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; in_we = vecs[i].we; out_ready = vecs[i].ready;
            in_addr = vecs[i].addr; in_data = vecs[i].data;
            step();
            chk($sformatf("vec%0d.count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d.valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.full", i), int'(in_full), int'(vecs[i].exp_full));
            chk($sformatf("vec%0d.ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d.addr", i), int'(out_addr), int'(vecs[i].exp_addr));
                chk($sformatf("vec%0d.data", i), int'(out_data), int'(vecs[i].exp_data));
            end
        end

        // simultaneous push/pop at count 3, then at full with a dropped write
        do_reset("rst_a", 1'b0);
        for (int i = 0; i < 3; i++) drive("pp_fill", 1'b1, 200 + i, 1000 + i, 1'b0);
        drive("pp3", 1'b1, 203, 1003, 1'b1);
        chk("pp3.count_is_3", int'(count), 3);
        for (int i = 0; i < 5; i++) drive("pp_fill2", 1'b1, 210 + i, 2000 + i, 1'b0);
        drive("pp8", 1'b1, 250, 2500, 1'b1);
        chk("pp8.count_is_7", int'(count), 7);
        chk("pp8.ovf_set", int'(overflow), 1);
        while (exp_q.size() > 0) drive("pp_drain", 1'b0, 0, 0, 1'b1);

        // pointer wrap: 20 writes interleaved with pops, occupancy kept in 1..5
        writes = 0;
        guard = 0;
        while ((writes < 20 || exp_q.size() > 0) && guard < 200) begin
            guard++;
            if (writes >= 20) begin
                w = 1'b0; r = 1'b1;
            end else if (exp_q.size() < 2) begin
                w = 1'b1; r = 1'b0;
            end else if (exp_q.size() >= 5) begin
                w = 1'b0; r = 1'b1;
            end else begin
                w = 1'b1; r = 1'($urandom_range(0, 1));
            end
            drive("wrap", w, 300 + writes, writes * 7 + 1, r);
            if (w) writes++;
        end
        chk("wrap.bounded", int'(guard < 200), 1);

        // reset mid-operation with a concurrent write
        for (int i = 0; i < 5; i++) drive("mid_fill", 1'b1, 600 + i, 600 + i, 1'b0);
        chk("mid.count5", int'(count), 5);
        do_reset("rst_mid", 1'b1);

        // same-address pair: merged with coalescing, two entries without
        drive("co1", 1'b1, 7, 1, 1'b0);
        drive("co2", 1'b1, 7, 2, 1'b0);
`ifdef VGA_WQ_COALESCE_EN
        chk("co.count", int'(count), 1);
        chk("co.head_data", int'(out_data), 2);
`else
        chk("co.count", int'(count), 2);
        chk("co.head_data", int'(out_data), 1);
`endif
        drive("co3", 1'b1, 7, 3, 1'b1);
`ifdef VGA_WQ_COALESCE_EN
        chk("co3.count", int'(count), 1);
        chk("co3.head_data", int'(out_data), 3);
`else
        chk("co3.count", int'(count), 2);
        chk("co3.head_data", int'(out_data), 2);
`endif
        while (exp_q.size() > 0) drive("co_drain", 1'b0, 0, 0, 1'b1);

        // final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
